// File: rtl/sha256_msg_schedule_pkg.sv
// Shared SHA-256 constants, FSM state type and small-sigma helpers.
// K table is used by the schedule top only when SHA256_SCHED_KT_ROM_EN is defined.
package sha256_pkg;

    localparam int unsigned SHA256_WORD_W = 32;
    localparam int unsigned SHA256_ROUNDS = 64;

    typedef enum logic {
        StIdle,
        StEmit
    } sched_state_e;

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sha256_ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sha256_ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / word-out stream bundle for the message schedule.
// Kt_o exists only when SHA256_SCHED_KT_ROM_EN is defined.
interface sha256_msg_schedule_if;
    import sha256_pkg::*;

    logic [511:0]               block_i;
    logic                       v_i;
    logic                       ready_o;
    logic                       v_o;
    logic                       yumi_i;
    logic [SHA256_WORD_W-1:0]   Wt_o;
    logic [5:0]                 t_o;
    logic                       last_o;
`ifdef SHA256_SCHED_KT_ROM_EN
    logic [SHA256_WORD_W-1:0]   Kt_o;

    modport master (output block_i, v_i, yumi_i,
                    input  ready_o, v_o, Wt_o, t_o, last_o, Kt_o);
    modport slave  (input  block_i, v_i, yumi_i,
                    output ready_o, v_o, Wt_o, t_o, last_o, Kt_o);
`else
    modport master (output block_i, v_i, yumi_i,
                    input  ready_o, v_o, Wt_o, t_o, last_o);
    modport slave  (input  block_i, v_i, yumi_i,
                    output ready_o, v_o, Wt_o, t_o, last_o);
`endif

endinterface

// File: rtl/sha256_msg_schedule_w_next.sv
// Combinational schedule expansion: next W from the window taps w[14], w[9], w[1], w[0].
// Independent of SHA256_SCHED_KT_ROM_EN.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] w14_i,
    input  logic [31:0] w9_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w0_i,
    output logic [31:0] w_next_o
);

    assign w_next_o = sha256_ssig1(w14_i) + w9_i + sha256_ssig0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block, streams W0..W(ROUNDS-1) via a 16-word window.
// Optional SHA256_SCHED_KT_ROM_EN adds Kt_o = K[t_o] from the package constant table.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    sha256_msg_schedule_if.slave     bus_io
);

    sched_state_e       state_q, state_d;
    logic [5:0]         t_q, t_d;
    logic [WORD_W-1:0]  w_q [16];
    logic [WORD_W-1:0]  w_d [16];
    logic [WORD_W-1:0]  w_next;
    logic               emit;

    sha256_w_next u_w_next (
        .w14_i    (w_q[14]),
        .w9_i     (w_q[9]),
        .w1_i     (w_q[1]),
        .w0_i     (w_q[0]),
        .w_next_o (w_next)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.v_i) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = bus_io.block_i[511 - 32*i -: 32];
                    end
                    t_d     = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (bus_io.yumi_i) begin
                    if (t_q == 6'(ROUNDS - 1)) begin
                        t_d     = '0;
                        state_d = StIdle;
                    end else begin
                        // Head word consumed: slide the window and refill the tail.
                        for (int i = 0; i < 15; i++) begin
                            w_d[i] = w_q[i+1];
                        end
                        w_d[15] = w_next;
                        t_d     = t_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            t_q     <= '0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
        end
    end

    assign emit           = (state_q == StEmit);
    assign bus_io.ready_o = (state_q == StIdle) && !reset_i;
    assign bus_io.v_o     = emit;
    assign bus_io.Wt_o    = w_q[0];
    assign bus_io.t_o     = t_q;
    assign bus_io.last_o  = emit && (t_q == 6'(ROUNDS - 1));

`ifdef SHA256_SCHED_KT_ROM_EN
    assign bus_io.Kt_o    = emit ? SHA256_K[t_q] : '0;
`endif

`ifndef SYNTHESIS
    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (reset_i)
        bus_io.yumi_i |-> bus_io.v_o);
`endif

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Message-schedule stage directly upstream of the SHA-256 compression round. It accepts one padded 512-bit block and streams the 64 schedule words W0..W63, one per accepted transfer, together with the round index. Each word feeds the compression round's Wt input. A 16-word sliding window expands the schedule on the fly, with no 64-word storage.

Parameters:
- ROUNDS, 64: number of schedule words emitted per block. The value is fixed for SHA-256; it is kept as a parameter only for reduced-round bring-up and must be in 17..64.
- WORD_W, 32: word width. Fixed at 32.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- block_i  input  512  padded message block. Word 0 is block_i[511:480], word 15 is block_i[31:0] (big-endian, FIPS 180-4 order).
- v_i  input  1  block_i valid.
- ready_o  output  1  block accepted on a cycle where v_i & ready_o.
- v_o  output  1  Wt_o / t_o / last_o valid.
- yumi_i  input  1  consumer takes the current word. Legal only when v_o=1.
- Wt_o  output  32  schedule word W[t_o].
- t_o  output  6  round index t, 0..ROUNDS-1.
- last_o  output  1  high with v_o when t_o==ROUNDS-1.
- Kt_o  output  32  round constant K[t_o]. Present only with SHA256_SCHED_KT_ROM_EN.

Behaviour:
- Reset (reset_i high at clock edge):
  - state=IDLE, t=0, window cleared to 0.
  - v_o=0, last_o=0, Wt_o=0, t_o=0.
  - ready_o=0 while reset_i is high; ready_o=1 from the first cycle after reset deasserts.
  - Reset mid-block aborts the block immediately; no further words are emitted.
- States:
  - IDLE: ready_o=1, v_o=0. On v_i=1, load window w[i] = block word i (i=0..15), t=0, and go to EMIT.
  - EMIT: ready_o=0, v_o=1, Wt_o=w[0] (registered head), t_o=t.
    - On yumi_i with t<ROUNDS-1: shift the window (w[i] <= w[i+1] for i=0..14), set w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0] mod 2^32, and t <= t+1.
    - On yumi_i with t==ROUNDS-1: go to IDLE and clear v_o.
    - With no yumi_i, hold all outputs stable.
- Small-sigma functions:
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - All additions are 32-bit and wrap; carries are discarded.
- Latency and throughput:
  - Block accepted at edge N gives W0 valid in the cycle after edge N.
  - With yumi_i tied high, one word per cycle; 64 words take 64 cycles.
  - After the final yumi the block returns to IDLE, so ready_o rises one cycle later. A new block cannot be loaded in the same cycle as the final yumi.
  - Per-block occupancy is 65 cycles minimum.
- Words 0..15 pass through unchanged. Window refills computed for t>=48 are never emitted and are harmless.
- Illegal stimulus:
  - v_i while ready_o=0 is ignored; the upstream must hold the block.
  - yumi_i while v_o=0 is ignored and flagged by a simulation-only assertion.
- Block input is sampled only at the accept edge; later changes on block_i have no effect.

Optional Feature:
- Macro SHA256_SCHED_KT_ROM_EN.
- Defined: a 64-entry constant ROM drives Kt_o = K[t_o], valid with v_o and reset to 0. The compression round can then take Wt_o and Kt_o from one source.
- Undefined: the Kt_o port and ROM are absent, and the round constant comes from elsewhere. All other behaviour is identical.

Decomposition:
- Package sha256_pkg holds:
  - WORD_W and the round-count constant.
  - State enum {IDLE, EMIT}.
  - The 64-entry K constant array.
  - Functions sha256_ssig0/sha256_ssig1, shared with any future scheduler variant.
- One sub-module is natural: sha256_w_next. It is combinational and computes the next W from w[14], w[9], w[1], w[0].
- The FSM, counter and window stay in the top module.

Test Plan:
- "abc" block (0x61626380, words 1..14 = 0, word 15 = 0x00000018), yumi_i=1 → W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000. t_o steps 0..63, last_o only at t_o=63.
- Same block with yumi_i random 30% duty → identical 64-word sequence; Wt_o/t_o stable while yumi_i=0; no word dropped or duplicated.
- Back-to-back blocks with v_i held high → ready_o=0 for 64 EMIT cycles, 1 cycle IDLE, second block's W0 appears exactly 65 cycles after the first W0.
- reset_i pulsed at t=20 → next cycle v_o=0, t_o=0. After reset deasserts, ready_o=1 and a fresh block restarts at W0.
- With SHA256_SCHED_KT_ROM_EN: Kt_o=0x428A2F98 at t=0, 0x71374491 at t=1, 0xC67178F2 at t=63. Without the macro, the build elaborates with no Kt_o port.
- Full 64-word output compared against a reference model for 1000 random blocks → exact match.
